// File: rtl/home_alarm_controller.sv
// -----------------------------------------------------------------------------
// home_alarm_controller
//
// Clocked arm/disarm controller for a home alarm. It takes level sensor inputs
// and a strobed passcode. It provides exit and entry delays, instant-trip
// zones, a sticky record of tripped sensors, and a lockout after repeated wrong
// codes.
//
// Optional feature (compile-time macro ALARM_TIMEOUT_EN):
//   defined   : the siren silences after ALARM_CYCLES and the system drops back
//               to ARMED. The trip record is kept.
//   undefined : ALARM holds until a good code or reset.
//
// Ports:
//   clk         in   1            system clock, rising edge
//   rst_n       in   1            synchronous active-low reset
//   sensors     in   NUM_SENSORS  level sensor inputs, 1 = triggered
//   code        in   CODE_W       passcode from the converter
//   code_valid  in   1            one-cycle strobe qualifying code
//   alarm       out  1            siren drive
//   active      out  1            armed (EXIT_DELAY/ARMED/ENTRY_DELAY/ALARM)
//   state_o     out  3            current state encoding
//   trip_latch  out  NUM_SENSORS  sensors that tripped while armed (sticky)
//   fail_cnt    out  clog2(MAX_FAIL+1)  consecutive wrong-code count
// -----------------------------------------------------------------------------
module home_alarm_controller #(
  parameter int                     NUM_SENSORS  = 3,
  parameter int                     CODE_W       = 5,
  parameter logic [CODE_W-1:0]      ARM_CODE     = 5'd4,
  parameter logic [NUM_SENSORS-1:0] INSTANT_MASK = 3'b110,
  parameter int                     EXIT_CYCLES  = 16,
  parameter int                     ENTRY_CYCLES = 32,
  parameter int                     MAX_FAIL     = 3,
  parameter int                     LOCK_CYCLES  = 64,
  parameter int                     ALARM_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SENSORS-1:0]           sensors,
  input  logic [CODE_W-1:0]                code,
  input  logic                             code_valid,
  output logic                             alarm,
  output logic                             active,
  output logic [2:0]                       state_o,
  output logic [NUM_SENSORS-1:0]           trip_latch,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  // One shared delay counter, sized for the longest delay. The siren timeout
  // is included so the width does not change between builds.
  localparam int MAX_AB  = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
  localparam int MAX_ABC = (MAX_AB > LOCK_CYCLES) ? MAX_AB : LOCK_CYCLES;
  localparam int MAX_CYC = (MAX_ABC > ALARM_CYCLES) ? MAX_ABC : ALARM_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Load values are N-1 so that a state entered at edge k leaves at edge k+N.
  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD  = CNT_W'(LOCK_CYCLES - 1);
`ifdef ALARM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ALARM_LD = CNT_W'(ALARM_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n, cnt_dec;
  logic [NUM_SENSORS-1:0]   trip_n;
  logic [FAIL_W-1:0]        fail_n;
  logic                     good, bad, penalty;
  logic                     hit_instant, hit_delay, cnt_zero;

  assign cnt_zero = (cnt == '0);
  assign cnt_dec  = cnt - 1'b1;

  always_comb begin
    good        = code_valid && (code == ARM_CODE);
    bad         = code_valid && (code != ARM_CODE);
    // Codes are ignored entirely while locked out.
    penalty     = bad && (state != S_LOCKOUT) && ((int'(fail_cnt) + 1) == MAX_FAIL);
    hit_instant = |(sensors & INSTANT_MASK);
    hit_delay   = |(sensors & ~INSTANT_MASK);

    // Wrong-code counter: a penalty wraps it to zero instead of reaching MAX_FAIL.
    fail_n = fail_cnt;
    if (state == S_LOCKOUT)  fail_n = '0;
    else if (good)           fail_n = '0;
    else if (bad)            fail_n = penalty ? '0 : fail_cnt + 1'b1;

    // Sensors are recorded in every armed-and-watching state, before any
    // transition. A good code arriving with a sensor still records it.
    trip_n = trip_latch;
    if (state == S_ARMED || state == S_ENTRY || state == S_ALARM)
      trip_n = trip_latch | sensors;

    state_n = state;
    cnt_n   = cnt;

    case (state)
      S_DISARMED: begin
        if (good) begin
          state_n = S_EXIT;
          cnt_n   = EXIT_LD;
          trip_n  = '0;
        end else if (penalty) begin
          state_n = S_LOCKOUT;
          cnt_n   = LOCK_LD;
        end
      end
      S_EXIT: begin
        if (good)          state_n = S_DISARMED;
        else if (cnt_zero) state_n = S_ARMED;
        else               cnt_n   = cnt_dec;
      end
      S_ARMED: begin
        if (good) begin
          state_n = S_DISARMED;
        end else if (penalty || hit_instant) begin
          state_n = S_ALARM;
`ifdef ALARM_TIMEOUT_EN
          cnt_n   = ALARM_LD;
`endif
        end else if (hit_delay) begin
          state_n = S_ENTRY;
          cnt_n   = ENTRY_LD;
        end
      end
      S_ENTRY: begin
        if (good) begin
          state_n = S_DISARMED;
        end else if (penalty || hit_instant || cnt_zero) begin
          state_n = S_ALARM;
`ifdef ALARM_TIMEOUT_EN
          cnt_n   = ALARM_LD;
`endif
        end else begin
          cnt_n   = cnt_dec;
        end
      end
      S_ALARM: begin
        // A penalty here only clears fail_cnt; the siren keeps sounding.
        if (good)          state_n = S_DISARMED;
`ifdef ALARM_TIMEOUT_EN
        else if (cnt_zero) state_n = S_ARMED;
        else               cnt_n   = cnt_dec;
`endif
      end
      S_LOCKOUT: begin
        if (cnt_zero) state_n = S_DISARMED;
        else          cnt_n   = cnt_dec;
      end
      default: begin
        // Unused encodings 6/7 fall back to a safe disarmed state.
        state_n = S_DISARMED;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state value so they match state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_DISARMED;
      cnt        <= '0;
      fail_cnt   <= '0;
      trip_latch <= '0;
      alarm      <= 1'b0;
      active     <= 1'b0;
      state_o    <= 3'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      fail_cnt   <= fail_n;
      trip_latch <= trip_n;
      alarm      <= (state_n == S_ALARM);
      active     <= (state_n == S_EXIT) || (state_n == S_ARMED) ||
                    (state_n == S_ENTRY) || (state_n == S_ALARM);
      state_o    <= state_n;
    end
  end

endmodule

// File: tb/tb_home_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_home_alarm_controller
//
// Drives directed and random traffic into home_alarm_controller. For every
// cycle, a reference model pushes the expected outputs into a queue. A
// separate monitor pops that queue after each rising edge and compares the
// entry with the DUT outputs. Delays are modelled as absolute deadlines.
// -----------------------------------------------------------------------------
module tb_home_alarm_controller;

  localparam int NS      = 3;
  localparam int CW      = 5;
  localparam int EXIT_C  = 4;
  localparam int ENTRY_C = 6;
  localparam int LOCK_C  = 8;
  localparam int MF      = 3;
  localparam int ALARM_C = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] sensors = '0;
  logic [CW-1:0] code = '0;
  logic          code_valid = 1'b0;
  logic          alarm, active;
  logic [2:0]    state_o;
  logic [NS-1:0] trip_latch;
  logic [1:0]    fail_cnt;

  home_alarm_controller #(
    .NUM_SENSORS(NS), .CODE_W(CW), .ARM_CODE(5'd4), .INSTANT_MASK(3'b110),
    .EXIT_CYCLES(EXIT_C), .ENTRY_CYCLES(ENTRY_C), .MAX_FAIL(MF),
    .LOCK_CYCLES(LOCK_C), .ALARM_CYCLES(ALARM_C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensors(sensors), .code(code),
    .code_valid(code_valid), .alarm(alarm), .active(active),
    .state_o(state_o), .trip_latch(trip_latch), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    st;
    logic          al;
    logic          ac;
    logic [NS-1:0] trip;
    logic [1:0]    fail;
    string         tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: mode 0..5, wrong-code run, trip record, and the
  // edge number at which the current timed state must end.
  int            m_mode = 0;
  int            m_fail = 0;
  logic [NS-1:0] m_trip = '0;
  int            m_dl   = 0;
  int            edge_n = 0;

  task automatic step(input logic rn, input logic [NS-1:0] s, input logic cv,
                      input logic [CW-1:0] c, input string tag);
    bit   good, bad, pen, inst, dly;
    int   nxt;
    exp_t e;
    @(negedge clk);
    rst_n = rn; sensors = s; code_valid = cv; code = c;
    edge_n++;
    if (!rn) begin
      m_mode = 0; m_fail = 0; m_trip = '0; m_dl = 0;
    end else begin
      good = cv && (c == 5'd4);
      bad  = cv && (c != 5'd4);
      pen  = 1'b0;
      inst = |(s & 3'b110);
      dly  = s[0];
      if (m_mode != 5) begin
        if (good) m_fail = 0;
        else if (bad) begin
          if (m_fail + 1 == MF) begin m_fail = 0; pen = 1'b1; end
          else m_fail = m_fail + 1;
        end
      end
      if (m_mode >= 2 && m_mode <= 4) m_trip = m_trip | s;
      nxt = m_mode;
      case (m_mode)
        0: if (good) begin nxt = 1; m_dl = edge_n + EXIT_C; m_trip = '0; end
           else if (pen) begin nxt = 5; m_dl = edge_n + LOCK_C; end
        1: if (good) nxt = 0; else if (edge_n == m_dl) nxt = 2;
        2: if (good) nxt = 0; else if (pen || inst) nxt = 4;
           else if (dly) begin nxt = 3; m_dl = edge_n + ENTRY_C; end
        3: if (good) nxt = 0; else if (pen || inst || edge_n == m_dl) nxt = 4;
        4: begin
             if (good) nxt = 0;
`ifdef ALARM_TIMEOUT_EN
             else if (edge_n == m_dl) nxt = 2;
`endif
           end
        5: if (edge_n == m_dl) nxt = 0;
        default: nxt = 0;
      endcase
      if (nxt == 4 && m_mode != 4) m_dl = edge_n + ALARM_C;
      m_mode = nxt;
    end
    e.st   = 3'(m_mode);
    e.al   = (m_mode == 4);
    e.ac   = (m_mode >= 1 && m_mode <= 4);
    e.trip = m_trip;
    e.fail = 2'(m_fail);
    e.tag  = tag;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, '0, 1'b0, '0, tag);
  endtask

  task automatic arm(input string tag);
    step(1'b1, '0, 1'b1, 5'd4, tag);
    idle(EXIT_C, tag);
  endtask

  // Monitor: one comparison for each rising edge that has an expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (state_o !== e.st || alarm !== e.al || active !== e.ac ||
          trip_latch !== e.trip || fail_cnt !== e.fail) begin
        errors++;
        $display("FAIL %s edge %0d: got st=%0d al=%b ac=%b trip=%b fail=%0d, want st=%0d al=%b ac=%b trip=%b fail=%0d",
                 e.tag, checks, state_o, alarm, active, trip_latch, fail_cnt,
                 e.st, e.al, e.ac, e.trip, e.fail);
      end
    end
  end

  initial begin
    step(1'b0, '0, 1'b0, '0, "reset");
    step(1'b0, 3'b111, 1'b1, 5'd4, "reset_hold");

    // Arm; the exit delay ignores every sensor.
    step(1'b1, '0, 1'b1, 5'd4, "arm");
    for (int i = 0; i < EXIT_C - 1; i++) step(1'b1, 3'b111, 1'b0, '0, "exit_ignore");
    idle(2, "armed");

    // Delayed zone: entry delay runs out into ALARM.
    step(1'b1, 3'b001, 1'b0, '0, "entry_start");
    idle(ENTRY_C + 2, "entry_timeout");
    step(1'b1, '0, 1'b1, 5'd4, "alarm_disarm");
    idle(1, "disarmed");

    // Disarm on the third entry-delay cycle.
    arm("rearm1");
    step(1'b1, 3'b001, 1'b0, '0, "entry2");
    idle(2, "entry2_wait");
    step(1'b1, '0, 1'b1, 5'd4, "entry_disarm");
    idle(ENTRY_C + 2, "no_alarm");

    // Instant zone.
    arm("rearm2");
    step(1'b1, 3'b100, 1'b0, '0, "instant");
    idle(1, "instant_hold");
    step(1'b1, '0, 1'b1, 5'd4, "instant_disarm");
    idle(1, "instant_off");

    // Three wrong codes cause lockout; good codes are ignored during lockout.
    step(1'b1, '0, 1'b1, 5'd7, "bad1");
    step(1'b1, '0, 1'b1, 5'd19, "bad2");
    step(1'b1, '0, 1'b1, 5'd31, "bad3_lock");
    for (int i = 0; i < LOCK_C; i++)
      step(1'b1, '0, (i % 2) == 0, 5'd4, "lock_ignore");
    idle(2, "lock_exit");

    // A good code beats a simultaneous sensor event.
    arm("rearm3");
    step(1'b1, 3'b110, 1'b1, 5'd4, "good_vs_sensor");
    idle(1, "good_vs_sensor_after");

    // Reset in the middle of the entry delay.
    arm("rearm4");
    step(1'b1, 3'b001, 1'b0, '0, "entry3");
    idle(2, "entry3_wait");
    step(1'b0, '0, 1'b0, '0, "mid_reset");
    idle(1, "post_reset");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [NS-1:0] s;
      logic          cv, rn;
      logic [CW-1:0] c;
      s  = ($urandom_range(0, 9) == 0) ? NS'($urandom) : '0;
      cv = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 1) == 0) ? 5'd4 : CW'($urandom);
      rn = ($urandom_range(0, 399) != 0);
      step(rn, s, cv, c, "random");
    end

    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
